// File: rtl/dispensador_rolhas_pkg.sv
// Shared bottling-line constants: state encodings for the cork dispenser and
// the sealing station, plus default hopper sizing.
package dispensador_rolhas_pkg;

   localparam int CAPACIDADE_PAD = 15;
   localparam int LIMIAR_PAD     = 3;

   typedef enum logic [1:0] {
      VAZIO   = 2'b00,
      PRONTO  = 2'b01,
      RECARGA = 2'b10
   } estado_t;

   typedef enum logic [1:0] {
      SEL_ESPERA = 2'b00,
      SEL_ROLHA  = 2'b01,
      SEL_PRENSA = 2'b10
   } estado_selagem_t;

endpackage

// File: rtl/dispensador_rolhas_saida.sv
// Moore output decode for the cork dispenser, built from gates on the state code.
module saida_dispensador
   import dispensador_rolhas_pkg::*;
(
   input  estado_t state,
   output logic    rolha,
   output logic    alarme
);

   assign rolha  = ~state[1] &  state[0];
   assign alarme = ~state[1] & ~state[0];

endmodule

// File: rtl/dispensador_rolhas.sv
// Cork hopper controller: feeds corks to the sealing head, counts one per rising
// edge of done, refills one per cycle while the operator holds recarga.
module dispensador_rolhas
   import dispensador_rolhas_pkg::*;
#(
   parameter int CAPACIDADE = CAPACIDADE_PAD,
   parameter int LIMIAR     = LIMIAR_PAD,
   parameter int LARGURA    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               done,
   input  logic               recarga,
   output logic               rolha,
   output logic [LARGURA-1:0] estoque,
   output logic               baixo,
   output logic               alarme
);

   localparam logic [LARGURA-1:0] CAP = LARGURA'(CAPACIDADE);
   localparam logic [LARGURA-1:0] LIM = LARGURA'(LIMIAR);
   localparam logic [LARGURA-1:0] UM  = LARGURA'(1);

   estado_t            state, state_n;
   logic [LARGURA-1:0] estoque_n;
   logic               done_q;
   logic               consumo;

   assign consumo = done & ~done_q;

   // done_q follows done even in reset so a held done is not taken as a new bottle
   always_ff @(posedge clk) begin
      done_q <= done;
      if (!reset) begin
         state   <= VAZIO;
         estoque <= '0;
      end else begin
         state   <= state_n;
         estoque <= estoque_n;
      end
   end

   always_comb begin
      state_n   = state;
      estoque_n = estoque;
      case (state)
         PRONTO: begin
            if (consumo) begin
               estoque_n = estoque - UM;
               if (estoque == UM) state_n = VAZIO;
            end else if (recarga && estoque < CAP) begin
               state_n = RECARGA;
            end
         end
         VAZIO: begin
            if (recarga) state_n = RECARGA;
         end
         RECARGA: begin
            // the increment that fills the hopper also leaves RECARGA
            if (recarga && estoque < CAP) begin
               estoque_n = estoque + UM;
               if (estoque + UM == CAP) state_n = PRONTO;
            end else begin
               state_n = (estoque != '0) ? PRONTO : VAZIO;
            end
         end
         default: begin
            state_n   = VAZIO;
            estoque_n = '0;
         end
      endcase
   end

   assign baixo = (estoque <= LIM);

   saida_dispensador u_saida (
      .state  (state),
      .rolha  (rolha),
      .alarme (alarme)
   );

endmodule

// File: tb/tb_dispensador_rolhas.sv
// Scoreboard bench for the cork dispenser: directed scenarios then random traffic.
module tb_dispensador_rolhas;

   localparam int CAP = 15;
   localparam int LIM = 3;

   logic       clk = 1'b0;
   logic       reset, done, recarga;
   logic       rolha, baixo, alarme;
   logic [3:0] estoque;

   typedef struct packed {
      logic [3:0] est;
      logic       rolha;
      logic       alarme;
      logic       baixo;
   } resp_t;

   typedef enum int {M_FEED, M_EMPTY, M_FILL} modo_t;

   resp_t exp_q[$];
   int    checks = 0;
   int    failures = 0;

   modo_t m_modo = M_EMPTY;
   int    m_stock = 0;
   bit    m_prev_done = 1'b0;

   dispensador_rolhas dut (
      .clk     (clk),
      .reset   (reset),
      .done    (done),
      .recarga (recarga),
      .rolha   (rolha),
      .estoque (estoque),
      .baixo   (baixo),
      .alarme  (alarme)
   );

   always #5 clk = ~clk;

   // reference: one call per clock edge with the inputs present at that edge
   task automatic model(input bit r, input bit d, input bit rq);
      bit borda;
      borda = d && !m_prev_done;
      m_prev_done = d;
      if (!r) begin
         m_stock = 0;
         m_modo  = M_EMPTY;
      end else begin
         case (m_modo)
            M_FEED: begin
               if (borda) begin
                  m_stock = m_stock - 1;
                  if (m_stock == 0) m_modo = M_EMPTY;
               end else if (rq && m_stock < CAP) begin
                  m_modo = M_FILL;
               end
            end
            M_EMPTY: if (rq) m_modo = M_FILL;
            default: begin
               if (rq && m_stock < CAP) begin
                  m_stock = m_stock + 1;
                  if (m_stock == CAP) m_modo = M_FEED;
               end else begin
                  m_modo = (m_stock > 0) ? M_FEED : M_EMPTY;
               end
            end
         endcase
      end
   endtask

   task automatic step(input bit r, input bit d, input bit rq);
      resp_t e;
      @(negedge clk);
      reset   = r;
      done    = d;
      recarga = rq;
      model(r, d, rq);
      e.est    = 4'(m_stock);
      e.rolha  = (m_modo == M_FEED);
      e.alarme = (m_modo == M_EMPTY);
      e.baixo  = (m_stock <= LIM);
      exp_q.push_back(e);
   endtask

   task automatic repete(input int n, input bit r, input bit d, input bit rq);
      for (int i = 0; i < n; i++) step(r, d, rq);
   endtask

   // monitor: outputs are presented every cycle, compare just after the edge
   always @(posedge clk) begin
      resp_t e, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{est: estoque, rolha: rolha, alarme: alarme, baixo: baixo};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL saidas t=%0t got est=%0d rolha=%b alarme=%b baixo=%b want est=%0d rolha=%b alarme=%b baixo=%b",
                     $time, a.est, a.rolha, a.alarme, a.baixo, e.est, e.rolha, e.alarme, e.baixo);
         end
      end
   end

   initial begin
      int dv;
      reset = 1'b0; done = 1'b0; recarga = 1'b0;
      // reset with done low
      repete(2, 0, 0, 0);
      // fill from empty, extra recarga cycles ignored at full
      repete(20, 1, 0, 1);
      // done held for 3 cycles counts once, then two single pulses
      repete(3, 1, 1, 0);
      step(1, 0, 0);
      repeat (2) begin step(1, 1, 0); step(1, 0, 0); end
      // drain to 1, last pulse empties, extra pulse ignored
      repeat (11) begin step(1, 1, 0); step(1, 0, 0); end
      step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
      step(1, 1, 0); step(1, 0, 0);
      // refill to 5, then done edge together with recarga
      repete(6, 1, 0, 1);
      step(1, 0, 0);
      step(1, 1, 1);
      repete(4, 1, 0, 1);
      step(1, 0, 0); step(1, 0, 0);
      // reset while refilling at 6
      repete(2, 0, 0, 0);
      repete(7, 1, 0, 1);
      step(0, 0, 1);
      step(1, 0, 0);
      // done held high across reset release is not a consumption
      repete(2, 0, 1, 0);
      repete(4, 1, 1, 1);
      repete(3, 1, 1, 0);
      step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
      // random traffic
      dv = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) dv = (dv == 0) ? 1 : 0;
         step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, dv[0],
              ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
      end
      @(posedge clk); #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL fila got %0d pending want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dispensador_rolhas.md
DISPENSADOR_ROLHAS -- requirements
Module: dispensador_rolhas

Interface
REQ-001 Parameter CAPACIDADE, default 15: maximum corks held in the hopper.
REQ-002 Parameter LIMIAR, default 3: low-stock warning threshold.
REQ-003 Parameter LARGURA, default 4: width of the stock counter; SHALL satisfy 2^LARGURA > CAPACIDADE.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 done  input  1  sealing-station "cork consumed" indication; high for at least one cycle per sealed bottle.
REQ-007 recarga  input  1  operator refill request; level-sensitive.
REQ-008 rolha  output  1  a cork is presented at the sealing head; this drives the sealing station's rolha input.
REQ-009 estoque  output  LARGURA  current cork count.
REQ-010 baixo  output  1  stock warning: estoque <= LIMIAR.
REQ-011 alarme  output  1  hopper empty and no refill in progress.

Function
REQ-012 The FSM SHALL have exactly three states:
- PRONTO: stock > 0, feeding.
- VAZIO: stock == 0.
- RECARGA: hopper open, refilling.
REQ-013 Outputs SHALL be Moore-decoded:
- rolha = (state == PRONTO).
- alarme = (state == VAZIO).
- baixo = (estoque <= LIMIAR), combinational from the counter.
REQ-014 The block SHALL register done each cycle (done_q) and form consumo = done & ~done_q; one bottle is counted per rising edge of done, regardless of how long done stays high.
REQ-015 In PRONTO, consumo SHALL decrement estoque by 1 on the next edge.
- If that decrement reaches 0, the next state SHALL be VAZIO; rolha drops one cycle after the consuming edge.
REQ-016 In PRONTO, recarga=1 with no consumo and estoque < CAPACIDADE SHALL move to RECARGA.
- In the same cycle, consumo and recarga SHALL both occur: consumo takes priority, the decrement happens, and the recarga request is re-evaluated next cycle.
REQ-017 In PRONTO with estoque == CAPACIDADE, recarga SHALL be ignored.
REQ-018 In VAZIO, recarga=1 SHALL move to RECARGA; otherwise the FSM stays in VAZIO. consumo in VAZIO SHALL be ignored, and the counter never underflows.
REQ-019 In RECARGA, estoque SHALL increment by 1 per cycle while recarga=1 and estoque < CAPACIDADE.
REQ-020 RECARGA SHALL exit as follows:
- When estoque reaches CAPACIDADE, or when recarga deasserts: go to PRONTO if estoque > 0, else VAZIO.
- Reaching CAPACIDADE SHALL exit on the same edge as the final increment.
REQ-021 consumo in RECARGA SHALL be ignored, since rolha=0 there and no cork is available.
REQ-022 estoque SHALL never exceed CAPACIDADE and never wrap below 0.

Reset
REQ-023 When reset=0 at a rising clk edge, the block SHALL apply:
- state = VAZIO, estoque = 0, done_q = 0.
- Resulting outputs: rolha=0, alarme=1, baixo=1.
REQ-024 Reset asserted mid-RECARGA or mid-consumption SHALL abandon the operation; the count is discarded, with no partial update on that edge.
REQ-025 On the first edge after reset release, if done is already high, it SHALL NOT count as consumo, because done_q cleared to 0 on the reset edge would otherwise pass it as an edge.
- Implementation: done_q SHALL load done during reset, so a held done is not seen as a new edge.
- Consequence: the reset value of done_q is 0 only when done=0 during reset.

Structure
REQ-026 The following SHALL reside in the shared bottling-line constants package, alongside the sealing FSM encodings:
- State encodings: PRONTO, VAZIO, RECARGA as 2-bit codes.
- Default CAPACIDADE and LIMIAR.
REQ-027 Output decoding SHALL be a separate gate-level sub-module, saida_dispensador (inputs: state; outputs: rolha, alarme), instantiated once.
REQ-028 The block SHALL contain no other sub-modules.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset with done=0: estoque=0, alarme=1, rolha=0, baixo=1.
- From VAZIO, hold recarga=1 for 20 cycles: estoque counts 1..15 in 15 cycles, then the FSM enters PRONTO with estoque=15, rolha=1, baixo=0; the remaining recarga cycles are ignored.
- In PRONTO with estoque=15, apply done high for 3 consecutive cycles: estoque=14 (single decrement), then 2 further single-cycle pulses give estoque=12.
- With estoque=1, a done pulse: estoque=0 and the FSM goes to VAZIO; rolha=0 and alarme=1 one cycle later; a further done pulse leaves estoque=0.
- With estoque=5, recarga and a new done edge in the same cycle: estoque=4, then RECARGA next cycle with increments until recarga is dropped at estoque=7, then PRONTO.
- reset=0 while in RECARGA at estoque=6: next cycle estoque=0, VAZIO, alarme=1.
